// File: rtl/usb_slave_pkg.sv
// Shared definitions for the USB slave send/receive packet engines:
// SIE control codes, PID nibbles, RxStatus bit positions and FSM encodings.
package usb_slave_pkg;

    localparam logic [7:0] CNTL_TX_PID = 8'h02;
    localparam logic [7:0] CNTL_RX_PID = 8'h02;
    localparam logic [7:0] CNTL_DATA   = 8'h03;
    localparam logic [7:0] CNTL_STOP   = 8'h04;

    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hb;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'ha;
    localparam logic [3:0] PID_STALL = 4'he;

    localparam int RXST_CRC_ERR   = 0;
    localparam int RXST_BS_ERR    = 1;
    localparam int RXST_OVERFLOW  = 2;
    localparam int RXST_TIMEOUT   = 3;
    localparam int RXST_PID_ERR   = 4;
    localparam int RXST_DATA1     = 5;
    localparam int RXST_ACK       = 6;
    localparam int RXST_STALL     = 7;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_PID  = 2'd1;
    localparam logic [1:0] S_WAIT_DATA = 2'd2;
    localparam logic [1:0] S_FINISH    = 2'd3;

    // A PID byte is valid when its upper nibble is the complement of the lower one.
    function automatic logic pid_check_ok(input logic [7:0] pid_byte);
        return (pid_byte[7:4] == ~pid_byte[3:0]);
    endfunction

endpackage

// File: rtl/slave_get_packet.sv
// USB slave receive-packet controller: validates the PID, streams DATA0/DATA1
// payload into the RX FIFO and reports a status byte back to the control FSM.
module slave_get_packet
    import usb_slave_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 720,
    parameter int CNT_W          = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             getPacketEn,
    output logic             getPacketRdy,
    input  logic [7:0]       rxPktData,
    input  logic [7:0]       rxPktCntl,
    input  logic             rxPktWEn,
    input  logic             fifoFull,
    output logic [7:0]       fifoData,
    output logic             fifoWEn,
    output logic [3:0]       RxPID,
    output logic [7:0]       RxStatus,
    output logic [CNT_W-1:0] rxByteCount
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_rdy;
    logic             r_fifo_wen;
    logic [7:0]       r_fifo_data;
    logic [3:0]       r_pid;
    logic [7:0]       r_status;
    logic [CNT_W-1:0] r_count;
    logic [TMR_W-1:0] r_timer;

    logic [1:0]       w_state;
    logic             w_rdy;
    logic             w_fifo_wen;
    logic [7:0]       w_fifo_data;
    logic [3:0]       w_pid;
    logic [7:0]       w_status;
    logic [CNT_W-1:0] w_count;
    logic [TMR_W-1:0] w_timer;

    logic             w_pid_strobe;
    logic             w_data_strobe;
    logic             w_stop_strobe;

    assign w_pid_strobe  = rxPktWEn && (rxPktCntl == CNTL_RX_PID);
    assign w_data_strobe = rxPktWEn && (rxPktCntl == CNTL_DATA);
    assign w_stop_strobe = rxPktWEn && (rxPktCntl == CNTL_STOP);

    // Next-state and next-output computation for the receive FSM.
    always_comb begin
        w_state     = r_state;
        w_rdy       = r_rdy;
        w_fifo_wen  = 1'b0;
        w_fifo_data = r_fifo_data;
        w_pid       = r_pid;
        w_status    = r_status;
        w_count     = r_count;
        w_timer     = r_timer;
        case (r_state)
            S_IDLE: begin
                if (getPacketEn) begin
                    w_state  = S_WAIT_PID;
                    w_rdy    = 1'b0;
                    w_status = 8'h00;
                    w_count  = {CNT_W{1'b0}};
                    w_timer  = {TMR_W{1'b0}};
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_WAIT_PID: begin
                w_timer = r_timer + TMR_W'(1);
                // A PID strobe takes priority over a coincident timeout.
                if (w_pid_strobe) begin
                    w_pid = rxPktData[3:0];
                    if (!pid_check_ok(rxPktData)) begin
                        w_status[RXST_PID_ERR] = 1'b1;
                        w_state                = S_FINISH;
                    end else if ((rxPktData[3:0] == PID_DATA0) || (rxPktData[3:0] == PID_DATA1)) begin
                        w_status[RXST_DATA1] = (rxPktData[3:0] == PID_DATA1);
                        w_state              = S_WAIT_DATA;
                    end else begin
                        w_status[RXST_ACK]   = (rxPktData[3:0] == PID_ACK);
                        w_status[RXST_STALL] = (rxPktData[3:0] == PID_STALL);
                        w_state              = S_FINISH;
                    end
                end else if (r_timer == TMR_LAST) begin
                    w_status[RXST_TIMEOUT] = 1'b1;
                    w_state                = S_FINISH;
                end else begin
                    w_state = S_WAIT_PID;
                end
            end
            S_WAIT_DATA: begin
                if (w_data_strobe) begin
                    if (!fifoFull) begin
                        w_fifo_data = rxPktData;
                        w_fifo_wen  = 1'b1;
                        if (r_count != {CNT_W{1'b1}}) begin
                            w_count = r_count + CNT_W'(1);
                        end else begin
                            w_count = r_count;
                        end
                    end else begin
                        w_status[RXST_OVERFLOW] = 1'b1;
                    end
                end else if (w_stop_strobe) begin
                    w_status[1:0] = r_status[1:0] | rxPktData[1:0];
                    w_state       = S_FINISH;
                end else begin
                    w_state = S_WAIT_DATA;
                end
            end
            S_FINISH: begin
                w_rdy   = 1'b1;
                w_state = S_IDLE;
            end
            default: begin
                w_rdy   = 1'b1;
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rdy       <= 1'b1;
            r_fifo_wen  <= 1'b0;
            r_fifo_data <= 8'h00;
            r_pid       <= 4'h0;
            r_status    <= 8'h00;
            r_count     <= {CNT_W{1'b0}};
            r_timer     <= {TMR_W{1'b0}};
        end else begin
            r_state     <= w_state;
            r_rdy       <= w_rdy;
            r_fifo_wen  <= w_fifo_wen;
            r_fifo_data <= w_fifo_data;
            r_pid       <= w_pid;
            r_status    <= w_status;
            r_count     <= w_count;
            r_timer     <= w_timer;
        end
    end

    assign getPacketRdy = r_rdy;
    assign fifoWEn      = r_fifo_wen;
    assign fifoData     = r_fifo_data;
    assign RxPID        = r_pid;
    assign RxStatus     = r_status;
    assign rxByteCount  = r_count;

endmodule

// File: tb/tb_slave_get_packet.sv
// Self-checking bench for slave_get_packet: FIFO bytes are scoreboarded through
// a queue, packet results are compared against hand-derived constants.
module tb_slave_get_packet;

    localparam int TO    = 16;
    localparam int CNT_W = 10;

    logic             clk;
    logic             rst;
    logic             getPacketEn;
    logic             getPacketRdy;
    logic [7:0]       rxPktData;
    logic [7:0]       rxPktCntl;
    logic             rxPktWEn;
    logic             fifoFull;
    logic [7:0]       fifoData;
    logic             fifoWEn;
    logic [3:0]       RxPID;
    logic [7:0]       RxStatus;
    logic [CNT_W-1:0] rxByteCount;

    int        n_checks;
    int        n_fail;
    int        n_writes;
    int        w0;
    logic [7:0] exp_q[$];

    slave_get_packet #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .getPacketEn(getPacketEn), .getPacketRdy(getPacketRdy),
        .rxPktData(rxPktData), .rxPktCntl(rxPktCntl), .rxPktWEn(rxPktWEn),
        .fifoFull(fifoFull), .fifoData(fifoData), .fifoWEn(fifoWEn),
        .RxPID(RxPID), .RxStatus(RxStatus), .rxByteCount(rxByteCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // FIFO write monitor: every write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (fifoWEn === 1'b1) begin
            n_writes = n_writes + 1;
            if (exp_q.size() == 0) begin
                chk("fifo_unexpected_write", {24'h0, fifoData}, 32'hFFFF_FFFF);
            end else begin
                chk("fifo_data", {24'h0, fifoData}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req();
        getPacketEn = 1'b1;
        step();
        getPacketEn = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] c);
        rxPktData = d;
        rxPktCntl = c;
        rxPktWEn  = 1'b1;
        step();
        rxPktWEn  = 1'b0;
    endtask

    task automatic chk_results(input string tag, input logic [3:0] pid,
                               input logic [7:0] st, input int cnt);
        chk({tag, "_rdy"},    {31'h0, getPacketRdy}, 32'h1);
        chk({tag, "_pid"},    {28'h0, RxPID}, {28'h0, pid});
        chk({tag, "_status"}, {24'h0, RxStatus}, {24'h0, st});
        chk({tag, "_count"},  {22'h0, rxByteCount}, cnt);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_writes = 0;
        rst = 1'b1; getPacketEn = 1'b0; rxPktData = 8'h00; rxPktCntl = 8'h00;
        rxPktWEn = 1'b0; fifoFull = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk_results("reset", 4'h0, 8'h00, 0);
        chk("reset_fifo_wen", {31'h0, fifoWEn}, 32'h0);

        // DATA0 packet with two payload bytes
        w0 = n_writes;
        req();
        chk("data0_req_rdy_low", {31'h0, getPacketRdy}, 32'h0);
        send(8'hC3, 8'h02);
        exp_q.push_back(8'h11); send(8'h11, 8'h03);
        exp_q.push_back(8'h22); send(8'h22, 8'h03);
        send(8'h00, 8'h04);
        chk("data0_finish_rdy_low", {31'h0, getPacketRdy}, 32'h0);
        step();
        chk_results("data0", 4'h3, 8'h00, 2);
        chk("data0_writes", n_writes - w0, 2);

        // ACK handshake
        w0 = n_writes;
        req();
        send(8'hD2, 8'h02);
        chk("ack_finish_rdy_low", {31'h0, getPacketRdy}, 32'h0);
        step();
        chk_results("ack", 4'h2, 8'h40, 0);
        chk("ack_writes", n_writes - w0, 0);

        // Corrupt PID: goes straight to FINISH; later data strobes are ignored
        w0 = n_writes;
        req();
        send(8'h5B, 8'h02);
        step();
        chk_results("badpid", 4'hB, 8'h10, 0);
        send(8'h99, 8'h03);
        step();
        chk("badpid_writes", n_writes - w0, 0);
        chk("badpid_count_hold", {22'h0, rxByteCount}, 0);

        // DATA1 with overflow on the second byte and CRC error at stop
        w0 = n_writes;
        req();
        send(8'h4B, 8'h02);
        exp_q.push_back(8'hA1); send(8'hA1, 8'h03);
        fifoFull = 1'b1;        send(8'hA2, 8'h03);
        fifoFull = 1'b0;
        exp_q.push_back(8'hA3); send(8'hA3, 8'h03);
        send(8'h01, 8'h04);
        step();
        chk_results("data1", 4'hB, 8'h25, 2);
        chk("data1_writes", n_writes - w0, 2);

        // Timeout: result valid exactly TO+2 cycles after the request cycle
        req();
        repeat (TO) step();
        chk("timeout_rdy_early", {31'h0, getPacketRdy}, 32'h0);
        step();
        chk_results("timeout", 4'hB, 8'h08, 0);

        // PID arriving on the timeout cycle suppresses the timeout
        req();
        repeat (TO - 1) step();
        send(8'hD2, 8'h02);
        step();
        chk_results("pid_vs_timeout", 4'h2, 8'h40, 0);

        // Reset in WAIT_DATA after one accepted byte, with a data strobe alongside rst
        req();
        send(8'hC3, 8'h02);
        exp_q.push_back(8'h55); send(8'h55, 8'h03);
        rst = 1'b1;
        rxPktData = 8'h66; rxPktCntl = 8'h03; rxPktWEn = 1'b1;
        step();
        rst = 1'b0; rxPktWEn = 1'b0;
        w0 = n_writes;
        chk_results("midrst", 4'h0, 8'h00, 0);
        chk("midrst_fifo_wen", {31'h0, fifoWEn}, 32'h0);
        chk("midrst_fifo_data", {24'h0, fifoData}, 32'h0);
        send(8'h77, 8'h03);
        send(8'h88, 8'h03);
        step();
        chk("midrst_idle_writes", n_writes - w0, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
